// File: rtl/iir_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : iir_pkg                                                           |
// | Brief  : Shared constants, commit-FSM state type and passthrough helper    |
// |          for the IIR biquad coefficient store.                             |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package iir_pkg;

    localparam int COEFS_PER_SOS = 5;

    localparam int K_B0 = 0;
    localparam int K_B1 = 1;
    localparam int K_B2 = 2;
    localparam int K_A1 = 3;
    localparam int K_A2 = 4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_t;

    // Unity gain in Q(coef_w-frac_w).frac_w, masked to coef_w bits.
    function automatic logic [63:0] passthrough_word(input int coef_w, input int frac_w);
        logic [63:0] w;
        w = 64'd1 << frac_w;
        if (coef_w < 64) begin
            w = w & ((64'd1 << coef_w) - 64'd1);
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iir_coeff_commit_fsm.sv
// +----------------------------------------------------------------------------+
// | Module : iir_coeff_commit_fsm                                              |
// | Brief  : IDLE/PENDING control for the shadow-to-active bank transfer.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module iir_coeff_commit_fsm
    import iir_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic commit,
    input  logic frame_start,
    output logic busy,
    output logic commit_done,
    output logic copy_en
);

    commit_state_t r_state;
    commit_state_t w_state_nxt;
    logic          r_commit_done;
    logic          w_copy_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_commit_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_commit_done <= w_copy_en;
        end
    end

    // commit together with frame_start in IDLE copies at once, skipping PENDING.
    always_comb begin
        w_state_nxt = r_state;
        w_copy_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (commit) begin
                    if (frame_start) begin
                        w_copy_en = 1'b1;
                    end else begin
                        w_state_nxt = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    w_copy_en   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy        = (r_state == ST_PENDING);
    assign commit_done = r_commit_done;
    assign copy_en     = w_copy_en;

endmodule

`default_nettype wire

// File: rtl/iir_coeff_bank.sv
// +----------------------------------------------------------------------------+
// | Module : iir_coeff_bank                                                    |
// | Brief  : Shadow/active biquad coefficient banks with frame-aligned commit. |
// |          IIR_COEFF_READBACK_EN adds a registered shadow readback port.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module iir_coeff_bank
    import iir_pkg::*;
#(
    parameter  int COEF_W = 24,
    parameter  int FRAC_W = 22,
    parameter  int N_SOS  = 4,
    localparam int ADDR_W = $clog2(COEFS_PER_SOS * N_SOS),
    localparam int IDX_W  = (N_SOS > 1) ? $clog2(N_SOS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              commit,
    input  logic              frame_start,
    output logic              busy,
    output logic              commit_done,
    output logic              wr_err,
    input  logic              err_clr,
`ifdef IIR_COEFF_READBACK_EN
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [COEF_W-1:0] rb_data,
`endif
    input  logic [IDX_W-1:0]  rd_sos_idx,
    output logic [COEF_W-1:0] b0,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] a2
);

    localparam int                c_NWORDS = COEFS_PER_SOS * N_SOS;
    localparam logic [COEF_W-1:0] c_PASS   = COEF_W'(passthrough_word(COEF_W, FRAC_W));

    logic [COEF_W-1:0] r_shadow     [c_NWORDS];
    logic [COEF_W-1:0] r_active     [c_NWORDS];
    logic [COEF_W-1:0] w_shadow_nxt [c_NWORDS];

    logic w_busy;
    logic w_copy_en;
    logic w_wr_acc;
    logic w_addr_ok;
    logic r_wr_err;

    logic [COEF_W-1:0] w_b0, w_b1, w_b2, w_a1, w_a2;
    logic [COEF_W-1:0] r_b0, r_b1, r_b2, r_a1, r_a2;

    iir_coeff_commit_fsm u_commit_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit      (commit),
        .frame_start (frame_start),
        .busy        (w_busy),
        .commit_done (commit_done),
        .copy_en     (w_copy_en)
    );

    assign wr_ready  = !w_busy;
    assign busy      = w_busy;
    assign w_wr_acc  = wr_valid && !w_busy;
    assign w_addr_ok = (wr_addr < ADDR_W'(c_NWORDS));

    // Forwarded shadow lets a write in the bypass-commit cycle land in the copy.
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int i = 0; i < c_NWORDS; i++) begin
            if (w_wr_acc && (wr_addr == ADDR_W'(i))) begin
                w_shadow_nxt[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NWORDS; i++) begin
                r_shadow[i] <= ((i % COEFS_PER_SOS) == K_B0) ? c_PASS : '0;
                r_active[i] <= ((i % COEFS_PER_SOS) == K_B0) ? c_PASS : '0;
            end
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_copy_en) begin
                r_active <= w_shadow_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_err <= 1'b0;
        end else if (err_clr) begin
            r_wr_err <= 1'b0;
        end else if (w_wr_acc && !w_addr_ok) begin
            r_wr_err <= 1'b1;
        end
    end

    assign wr_err = r_wr_err;

    // Unmatched index (>= N_SOS) leaves all five outputs at zero.
    always_comb begin
        w_b0 = '0;
        w_b1 = '0;
        w_b2 = '0;
        w_a1 = '0;
        w_a2 = '0;
        for (int s = 0; s < N_SOS; s++) begin
            if (rd_sos_idx == IDX_W'(s)) begin
                w_b0 = r_active[s*COEFS_PER_SOS + K_B0];
                w_b1 = r_active[s*COEFS_PER_SOS + K_B1];
                w_b2 = r_active[s*COEFS_PER_SOS + K_B2];
                w_a1 = r_active[s*COEFS_PER_SOS + K_A1];
                w_a2 = r_active[s*COEFS_PER_SOS + K_A2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b0 <= c_PASS;
            r_b1 <= '0;
            r_b2 <= '0;
            r_a1 <= '0;
            r_a2 <= '0;
        end else begin
            r_b0 <= w_b0;
            r_b1 <= w_b1;
            r_b2 <= w_b2;
            r_a1 <= w_a1;
            r_a2 <= w_a2;
        end
    end

    assign b0 = r_b0;
    assign b1 = r_b1;
    assign b2 = r_b2;
    assign a1 = r_a1;
    assign a2 = r_a2;

`ifdef IIR_COEFF_READBACK_EN
    logic [COEF_W-1:0] w_rb;
    logic [COEF_W-1:0] r_rb;

    always_comb begin
        w_rb = '0;
        for (int i = 0; i < c_NWORDS; i++) begin
            if (rb_addr == ADDR_W'(i)) begin
                w_rb = r_shadow[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb <= '0;
        end else begin
            r_rb <= w_rb;
        end
    end

    assign rb_data = r_rb;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iir_coeff_bank.sv
// +----------------------------------------------------------------------------+
// | Module : tb_iir_coeff_bank                                                 |
// | Brief  : Scoreboard bench for iir_coeff_bank against a bank-level model.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_iir_coeff_bank;

    localparam int          COEF_W = 24;
    localparam int          FRAC_W = 22;
    localparam int          N_SOS  = 4;
    localparam int          NW     = 5 * N_SOS;
    localparam int          AW     = 5;
    localparam int          IW     = 2;
    localparam logic [23:0] PASS   = 24'h400000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          commit = 1'b0;
    logic          frame_start = 1'b0;
    logic          busy;
    logic          commit_done;
    logic          wr_err;
    logic          err_clr = 1'b0;
    logic [IW-1:0] rd_sos_idx = '0;
    logic [23:0]   b0, b1, b2, a1, a2;
`ifdef IIR_COEFF_READBACK_EN
    logic [AW-1:0] rb_addr = '0;
    logic [23:0]   rb_data;
`endif

    iir_coeff_bank #(
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W),
        .N_SOS  (N_SOS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .frame_start (frame_start),
        .busy        (busy),
        .commit_done (commit_done),
        .wr_err      (wr_err),
        .err_clr     (err_clr),
`ifdef IIR_COEFF_READBACK_EN
        .rb_addr     (rb_addr),
        .rb_data     (rb_data),
`endif
        .rd_sos_idx  (rd_sos_idx),
        .b0          (b0),
        .b1          (b1),
        .b2          (b2),
        .a1          (a1),
        .a2          (a2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   status;   // {wr_ready, busy, commit_done, wr_err}
        logic [119:0] coefs;    // {b0, b1, b2, a1, a2}
        logic [23:0]  rb;
    } exp_t;

    exp_t        sb_q[$];
    logic [23:0] m_sh  [NW];
    logic [23:0] m_act [NW];
    bit          m_pend;
    bit          m_err;
    int          checks   = 0;
    int          failures = 0;
    bit          issue    = 1'b0;
    bit          mon_en   = 1'b0;

    always @(posedge clk) mon_en <= issue;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_sh[i]  = ((i % 5) == 0) ? PASS : 24'h0;
            m_act[i] = m_sh[i];
        end
        m_pend = 1'b0;
        m_err  = 1'b0;
    endtask

    // One cycle of stimulus; the expected post-edge view goes to the scoreboard.
    task automatic step(input bit wv = 1'b0, input logic [AW-1:0] wa = '0,
                        input logic [23:0] wd = '0, input bit cm = 1'b0,
                        input bit fs = 1'b0, input bit ec = 1'b0,
                        input logic [IW-1:0] ri = '0, input logic [AW-1:0] ra = '0);
        exp_t e;
        bit   eset;
        bit   copy;
        int   base;
        @(posedge clk);
        #1;
        wr_valid    = wv;
        wr_addr     = wa;
        wr_data     = wd;
        commit      = cm;
        frame_start = fs;
        err_clr     = ec;
        rd_sos_idx  = ri;
`ifdef IIR_COEFF_READBACK_EN
        rb_addr     = ra;
`endif
        base    = int'(ri) * 5;
        e.coefs = {m_act[base], m_act[base+1], m_act[base+2], m_act[base+3], m_act[base+4]};
        e.rb    = (int'(ra) < NW) ? m_sh[ra] : 24'h0;
        eset    = 1'b0;
        if (wv && !m_pend) begin
            if (int'(wa) < NW) m_sh[wa] = wd;
            else eset = 1'b1;
        end
        copy = fs && (m_pend || cm);
        if (copy) m_act = m_sh;
        m_pend   = m_pend ? !fs : (cm && !fs);
        m_err    = ec ? 1'b0 : (m_err || eset);
        e.status = {!m_pend, m_pend, copy, m_err};
        sb_q.push_back(e);
        issue = 1'b1;
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        issue       = 1'b0;
        wr_valid    = 1'b0;
        commit      = 1'b0;
        frame_start = 1'b0;
        err_clr     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow t=%0t actual=empty required=entry", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("status", {124'h0, wr_ready, busy, commit_done, wr_err}, {124'h0, e.status});
                check("coefs", {8'h0, b0, b1, b2, a1, a2}, {8'h0, e.coefs});
`ifdef IIR_COEFF_READBACK_EN
                check("rb_data", {104'h0, rb_data}, {104'h0, e.rb});
`endif
            end
        end
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", {124'h0, wr_ready, busy, commit_done, wr_err}, {124'h0, 4'b1000});
        check("rst_coefs", {8'h0, b0, b1, b2, a1, a2}, {8'h0, PASS, 96'h0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < N_SOS; s++) step(.ri(IW'(s)));

        // Shadow write stays invisible until a frame-aligned commit.
        step(.wv(1'b1), .wa(5'd6), .wd(24'h123456), .ri(2'd1), .ra(5'd6));
        step(.ri(2'd1), .ra(5'd6));
        step(.cm(1'b1), .ri(2'd1));
        for (int i = 0; i < 4; i++) step(.wv(1'b1), .wa(5'd8), .wd(24'hBADBAD), .ri(2'd1));
        step(.fs(1'b1), .wv(1'b1), .wa(5'd8), .wd(24'hBADBAD), .ri(2'd1), .ra(5'd8));
        step(.ri(2'd1), .ra(5'd8));
        step(.ri(2'd1));

        // Bypass commit with a same-cycle write.
        step(.wv(1'b1), .wa(5'd7), .wd(24'h0ABCDE), .cm(1'b1), .fs(1'b1), .ri(2'd1));
        step(.ri(2'd1), .ra(5'd7));
        step(.wv(1'b1), .wa(5'd3), .wd(24'hFFF000), .ri(2'd1));
        step(.ra(5'd3));

        // Out-of-range write and sticky error, including clear-over-set.
        step(.wv(1'b1), .wa(5'd20), .wd(24'h777777), .ra(5'd20));
        step(.ri(2'd3));
        step(.wv(1'b1), .wa(5'd23), .wd(24'h111111), .ec(1'b1));
        step();
        step(.wv(1'b1), .wa(5'd31), .wd(24'h222222));
        step(.ec(1'b1));
        step();

        // Asynchronous reset while a commit is pending.
        step(.cm(1'b1), .ri(2'd1));
        step(.ri(2'd1));
        go_idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_status", {124'h0, wr_ready, busy, commit_done, wr_err}, {124'h0, 4'b1000});
        check("arst_coefs", {8'h0, b0, b1, b2, a1, a2}, {8'h0, PASS, 96'h0});
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(.fs(1'b1), .ri(2'd1));
        for (int s = 0; s < N_SOS; s++) step(.ri(IW'(s)));

        // Randomised traffic.
        for (int n = 0; n < 500; n++) begin
            step(.wv($urandom_range(0, 1) == 1),
                 .wa(AW'($urandom_range(0, 23))),
                 .wd(24'($urandom())),
                 .cm($urandom_range(0, 7) == 0),
                 .fs($urandom_range(0, 4) == 0),
                 .ec($urandom_range(0, 15) == 0),
                 .ri(IW'($urandom_range(0, N_SOS - 1))),
                 .ra(AW'($urandom_range(0, 23))));
        end

        go_idle();
        repeat (2) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iir_coeff_bank.md
# iir_coeff_bank

Runtime-reloadable coefficient store for the biquad (SOS) cascade of the IIR filter. It holds a shadow bank written over a simple valid/ready port and an active bank read by the cascade datapath. The shadow bank is copied atomically into the active bank at a sample-frame boundary, so a sample is never filtered with a mix of old and new coefficients. It is the parametrised successor of the fixed four-section, file-initialised coefficient table.

## Interface
- `COEF_W`, 24: coefficient width, signed two's complement.
- `FRAC_W`, 22: fractional bits of the coefficient format (Q(COEF_W-FRAC_W).FRAC_W).
- `N_SOS`, 4: number of biquad sections; legal range 1..16.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `wr_valid` in 1: shadow write request.
- `wr_ready` out 1: shadow write may be accepted.
- `wr_addr` in `$clog2(5*N_SOS)`: word address `sos*5 + k`, where k is 0..4 for b0, b1, b2, a1, a2.
- `wr_data` in `COEF_W`: coefficient value.
- `commit` in 1: single-cycle pulse requesting shadow→active transfer.
- `frame_start` in 1: pulse from the cascade at the start of each new input sample.
- `busy` out 1: a commit is pending.
- `commit_done` out 1: single-cycle pulse in the cycle the active bank updates.
- `wr_err` out 1: sticky flag for an out-of-range write address.
- `err_clr` in 1: clears `wr_err`.
- `rd_sos_idx` in `$clog2(N_SOS)` (min 1): section selected for readout.
- `b0`, `b1`, `b2`, `a1`, `a2` out `COEF_W` each: registered active-bank coefficients.

## Operation
- Storage: two flop arrays, shadow and active, each 5*N_SOS × COEF_W.
- Reset value of both banks: passthrough. Every section has b0 = 1 << FRAC_W and b1, b2, a1, a2 = 0.
- Writes:
  - A write is accepted when `wr_valid && wr_ready` and updates the shadow entry at `wr_addr`.
  - `wr_ready` = !`busy`.
  - An address ≥ 5*N_SOS is accepted but dropped, and sets `wr_err`.
  - `err_clr` has priority over a set occurring in the same cycle.
- Commit FSM, two states:
  - IDLE: `commit` moves to PENDING.
  - PENDING: `frame_start` copies shadow to active, pulses `commit_done`, and returns to IDLE. `commit` in PENDING is ignored.
- `busy` = (state == PENDING).
- Simultaneous events:
  - `commit` and `frame_start` in the same IDLE cycle: the copy happens in that cycle (bypass), with no PENDING cycle.
  - An accepted write in the same cycle as that bypassed copy is included in the copy, through a shadow-next forward.
- Readout:
  - Outputs are registered from the active bank at `rd_sos_idx`.
  - `rd_sos_idx` ≥ N_SOS drives all five outputs to 0.
- Reset mid-operation: pending commit discarded, both banks restored to passthrough, `wr_err` cleared.

## Timing
- Reset values: `wr_ready` = 1; `busy`, `commit_done`, `wr_err` = 0; b0 = 1 << FRAC_W; b1, b2, a1, a2 = 0.
- Write-to-shadow: 1 cycle. Read latency: 1 cycle from `rd_sos_idx` to the outputs.
- Commit:
  - The active bank changes on the `frame_start` edge.
  - A readout issued in the cycle of `frame_start` returns the old bank.
  - A readout issued the following cycle returns the new bank.
- `commit_done` is high for exactly the one cycle after the copy edge, registered.
- `busy` falls in the same cycle `commit_done` rises.

## Configuration
- `IIR_COEFF_READBACK_EN` defined:
  - Adds input `rb_addr` (width as `wr_addr`) and output `rb_data` (`COEF_W`).
  - `rb_data` returns the shadow entry, registered, 1-cycle latency.
  - An out-of-range `rb_addr` returns 0.
- Not defined: the ports are absent and no readback mux is built.

## Structure
- Shared package `iir_pkg`:
  - coefficient index constants `K_B0`..`K_A2`, value 0..4;
  - `COEFS_PER_SOS` = 5;
  - a function returning the passthrough word for a given COEF_W/FRAC_W.
- Sub-module `iir_coeff_commit_fsm`: the IDLE/PENDING control, producing `busy`, `commit_done` and the copy enable.

## Test plan
- Reset, then read sections 0..3 → b0 = 0x400000, all other outputs 0; `wr_ready` = 1.
- Write section 1 b1 = 0x123456, then read section 1 without a commit → b1 still 0. Pulse `commit`, then `frame_start` 5 cycles later → `busy` high for those 5 cycles; after the swap, the next read returns b1 = 0x123456.
- Hold `wr_valid` high while PENDING → no write is accepted until `commit_done`. Drive `commit`, `frame_start` and a write to addr 7 in the same cycle → `commit_done` next cycle, and section 1 b2 holds the written value.
- Write to addr 20 with N_SOS = 4 → `wr_err` = 1, banks unchanged. Pulse `err_clr` → `wr_err` = 0.
- Assert `rst_n` low while PENDING → `busy` = 0 immediately (asynchronous), passthrough values restored, no `commit_done`.
- With `IIR_COEFF_READBACK_EN`: write addr 3 = 0xFFF000 → `rb_data` = 0xFFF000 one cycle after `rb_addr` = 3.
